// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the pipeline data-memory port.
//
// Accepts one RV64I load/store at a time over a valid/ready handshake, performs
// it against an internal array of 2^(ADDR_W-3) doublewords, and returns the
// response LATENCY cycles after the accept edge.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned accesses fault (rsp_err=1, no write, rdata=0)
//   undefined : lane is masked to natural alignment and the access proceeds
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we                   1 = store, 0 = load
//   req_addr                 64-bit byte address
//   req_funct3               RV64I load/store funct3
//   req_wdata                store data, right-aligned
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata                extended load data (0 for stores and errors)
//   rsp_err                  access faulted, no state change
module dmem_responder #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Depth = 2 ** (ADDR_W - 3);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [Depth];

  // Address decode
  logic [ADDR_W-4:0] idx;
  logic [2:0]        lane_raw;
  logic [2:0]        size_mask;
  logic [2:0]        lane;
  logic [5:0]        shamt;
  logic              out_of_range;
  logic              illegal;
  logic              err;
  logic              accept;
  logic              wr_en;

  assign idx      = req_addr[ADDR_W-1:3];
  assign lane_raw = req_addr[2:0];

  always_comb begin
    size_mask = 3'b000;
    unique case (req_funct3[1:0])
      2'b00: size_mask = 3'b000;
      2'b01: size_mask = 3'b001;
      2'b10: size_mask = 3'b011;
      2'b11: size_mask = 3'b111;
      default: size_mask = 3'b000;
    endcase
  end

  // Lane forced to natural alignment; in trap mode misaligned cases fault anyway.
  assign lane  = lane_raw & ~size_mask;
  assign shamt = {lane, 3'b000};

  assign out_of_range = |(req_addr >> ADDR_W);
  assign illegal      = req_we ? req_funct3[2] : (req_funct3 == 3'b111);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(lane_raw & size_mask);
  assign err        = out_of_range | illegal | misaligned;
`else
  assign err        = out_of_range | illegal;
`endif

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_we && !err;

  // Load path
  logic [63:0] rd_word;
  logic [63:0] rd_sh;
  logic [63:0] load_data;

  assign rd_word = mem[idx];
  assign rd_sh   = rd_word >> shamt;

  always_comb begin
    load_data = 64'h0;
    unique case (req_funct3)
      3'b000: load_data = {{56{rd_sh[7]}}, rd_sh[7:0]};
      3'b001: load_data = {{48{rd_sh[15]}}, rd_sh[15:0]};
      3'b010: load_data = {{32{rd_sh[31]}}, rd_sh[31:0]};
      3'b011: load_data = rd_sh;
      3'b100: load_data = {56'h0, rd_sh[7:0]};
      3'b101: load_data = {48'h0, rd_sh[15:0]};
      3'b110: load_data = {32'h0, rd_sh[31:0]};
      default: load_data = 64'h0;
    endcase
  end

  // Store path
  logic [63:0] wr_data;
  logic [7:0]  base_mask;
  logic [7:0]  byte_mask;

  assign wr_data = req_wdata << shamt;

  always_comb begin
    base_mask = 8'h00;
    unique case (req_funct3[1:0])
      2'b00: base_mask = 8'h01;
      2'b01: base_mask = 8'h03;
      2'b10: base_mask = 8'h0F;
      2'b11: base_mask = 8'hFF;
      default: base_mask = 8'h00;
    endcase
  end

  assign byte_mask = base_mask << lane;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_mask[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rdata_d = (req_we || err) ? 64'h0 : load_data;
          err_d   = err;
          if (LATENCY == 1) begin
            state_d = StResp;
            cnt_d   = 4'd0;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 64'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
